// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like slave port between the instruction-fetch and load/store requesters.
// One transaction in flight at a time; data has priority, with a starvation guard for inst.
module sram_req_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             grant_inst_q, grant_inst_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             any_req_s;
  logic             pick_inst_s;
  logic             arb_s;

  assign any_req_s   = inst_req | data_req;
  assign pick_inst_s = inst_req & (~data_req | (starve_cnt_q == CNT_LIM));

  // State, grant owner and starvation counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_inst_q <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_inst_q <= grant_inst_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Next state; arbitration happens from IDLE or on the closing data_ok of a transaction
  always_comb begin
    state_d      = state_q;
    grant_inst_d = grant_inst_q;
    starve_cnt_d = starve_cnt_q;
    arb_s        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          arb_s   = 1'b1;
          state_d = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (mem_addr_ok) begin
          state_d = S_DATA;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (mem_data_ok && any_req_s) begin
          arb_s   = 1'b1;
          state_d = S_ADDR;
        end else if (mem_data_ok) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (arb_s) begin
      grant_inst_d = pick_inst_s;
      if (!pick_inst_s && inst_req) begin
        starve_cnt_d = (starve_cnt_q == CNT_LIM) ? CNT_LIM : starve_cnt_q + CNT_W'(1);
      end else begin
        starve_cnt_d = '0;
      end
    end else begin
      grant_inst_d = grant_inst_q;
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Outputs: slave request mux in ADDR, response routing in DATA, everything else quiet
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_wstrb    = 4'd0;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    case (state_q)
      S_ADDR: begin
        mem_req = 1'b1;
        if (grant_inst_q) begin
          mem_wr       = inst_wr;
          mem_size     = inst_size;
          mem_wstrb    = inst_wstrb;
          mem_addr     = inst_addr;
          mem_wdata    = inst_wdata;
          inst_addr_ok = mem_addr_ok;
        end else begin
          mem_wr       = data_wr;
          mem_size     = data_size;
          mem_wstrb    = data_wstrb;
          mem_addr     = data_addr;
          mem_wdata    = data_wdata;
          data_addr_ok = mem_addr_ok;
        end
      end
      S_DATA: begin
        if (grant_inst_q) begin
          inst_data_ok = mem_data_ok;
          inst_rdata   = mem_rdata;
        end else begin
          data_data_ok = mem_data_ok;
          data_rdata   = mem_rdata;
        end
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: a cycle-by-cycle vector table plus hand-written
// sequences for starvation, write pass-through, slave stall and asynchronous reset.
module tb_sram_req_arbiter;

  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h1c00_0200;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        ir, dr, mao, mdo;
    logic [31:0] rd;
    logic        e_mreq;
    logic [31:0] e_maddr;
    logic        e_iao, e_dao, e_ido, e_ddo;
    logic [31:0] e_ird, e_drd;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic dr, input logic mao, input logic mdo,
                              input logic [31:0] rd, input logic e_mreq, input logic [31:0] e_maddr,
                              input logic e_iao, input logic e_dao, input logic e_ido,
                              input logic e_ddo, input logic [31:0] e_ird, input logic [31:0] e_drd);
    vec_t v;
    v.ir = ir; v.dr = dr; v.mao = mao; v.mdo = mdo; v.rd = rd;
    v.e_mreq = e_mreq; v.e_maddr = e_maddr; v.e_iao = e_iao; v.e_dao = e_dao;
    v.e_ido = e_ido; v.e_ddo = e_ddo; v.e_ird = e_ird; v.e_drd = e_drd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " ctrl"}, {26'd0, mem_req, mem_wr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
    chk({tag, " payload"}, mem_addr | mem_wdata | {26'd0, mem_size, mem_wstrb}, 32'd0);
    chk({tag, " rdata"}, inst_rdata | data_rdata, 32'd0);
  endtask

  task automatic set_std_payload();
    inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hf; inst_addr = IA; inst_wdata = 32'h1111_0000;
    data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hf; data_addr = DA; data_wdata = 32'h2222_0000;
  endtask

  vec_t tbl[13];
  logic exp_g[10];
  logic got_g[10];
  int   ngr;

  initial begin
    // data read single, then simultaneous requests with no IDLE bubble
    tbl[0]  = mk(0,1,0,0,32'h0,          0,32'h0,0,0,0,0,32'h0,32'h0);
    tbl[1]  = mk(0,1,1,0,32'h0,          1,DA,   0,1,0,0,32'h0,32'h0);
    tbl[2]  = mk(0,0,0,0,32'h1111_1111,  0,32'h0,0,0,0,0,32'h0,32'h1111_1111);
    tbl[3]  = mk(0,0,0,1,32'hDEAD_BEEF,  0,32'h0,0,0,0,1,32'h0,32'hDEAD_BEEF);
    tbl[4]  = mk(0,0,1,1,32'hCAFE_F00D,  0,32'h0,0,0,0,0,32'h0,32'h0);
    tbl[5]  = mk(1,1,0,0,32'h0,          0,32'h0,0,0,0,0,32'h0,32'h0);
    tbl[6]  = mk(1,1,1,0,32'h0,          1,DA,   0,1,0,0,32'h0,32'h0);
    tbl[7]  = mk(1,0,0,0,32'h0,          0,32'h0,0,0,0,0,32'h0,32'h0);
    tbl[8]  = mk(1,0,0,1,32'h1234_5678,  0,32'h0,0,0,0,1,32'h0,32'h1234_5678);
    tbl[9]  = mk(1,0,0,0,32'h0,          1,IA,   0,0,0,0,32'h0,32'h0);
    tbl[10] = mk(1,0,1,0,32'h0,          1,IA,   1,0,0,0,32'h0,32'h0);
    tbl[11] = mk(0,0,0,1,32'h0BAD_F00D,  0,32'h0,0,0,1,0,32'h0BAD_F00D,32'h0);
    tbl[12] = mk(0,0,0,0,32'h0,          0,32'h0,0,0,0,0,32'h0,32'h0);
    for (int i = 0; i < 10; i++) exp_g[i] = (i == 4 || i == 9);

    // reset: outputs quiet even with requests and slave responses present
    reset = 1'b1;
    set_std_payload();
    inst_req = 1'b0; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    chk_quiet("reset");
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      inst_req = tbl[i].ir; data_req = tbl[i].dr;
      mem_addr_ok = tbl[i].mao; mem_data_ok = tbl[i].mdo; mem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("vec%0d mem_req", i), {31'd0, mem_req}, {31'd0, tbl[i].e_mreq});
      chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].e_maddr);
      chk($sformatf("vec%0d ok_bits", i), {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
          {28'd0, tbl[i].e_iao, tbl[i].e_dao, tbl[i].e_ido, tbl[i].e_ddo});
      chk($sformatf("vec%0d inst_rdata", i), inst_rdata, tbl[i].e_ird);
      chk($sformatf("vec%0d data_rdata", i), data_rdata, tbl[i].e_drd);
      tick();
    end

    // starvation guard: both requesters always asking, slave always ready
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0;
    ngr = 0;
    for (int cyc = 0; cyc < 40 && ngr < 10; cyc++) begin
      #1;
      if (inst_addr_ok || data_addr_ok) begin
        got_g[ngr] = inst_addr_ok;
        chk($sformatf("starve single grant %0d", ngr), {31'd0, inst_addr_ok & data_addr_ok}, 32'd0);
        ngr++;
      end
      if (ngr < 10) tick();
    end
    chk("starve grant count", ngr, 10);
    for (int i = 0; i < ngr; i++)
      chk($sformatf("starve grant%0d is_inst", i), {31'd0, got_g[i]}, {31'd0, exp_g[i]});
    tick();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #1;
    chk("starve drain inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    tick();
    mem_data_ok = 1'b0;
    #1;
    chk_quiet("starve idle");

    // write pass-through
    data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'b1100; data_addr = 32'h1c00_0302;
    data_wdata = 32'hABCD_0000; data_req = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      mem_addr_ok = (k == 1);
      #1;
      chk($sformatf("wr%0d mem_req/wr", k), {30'd0, mem_req, mem_wr}, 32'd3);
      chk($sformatf("wr%0d size/wstrb", k), {26'd0, mem_size, mem_wstrb}, {26'd0, 2'd1, 4'b1100});
      chk($sformatf("wr%0d mem_addr", k), mem_addr, 32'h1c00_0302);
      chk($sformatf("wr%0d mem_wdata", k), mem_wdata, 32'hABCD_0000);
      chk($sformatf("wr%0d data_addr_ok", k), {31'd0, data_addr_ok}, k);
      tick();
    end
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #1;
    chk("wr ack data_data_ok", {31'd0, data_data_ok}, 32'd1);
    tick();
    mem_data_ok = 1'b0;

    // slave stalls addr_ok for 5 cycles; inst rises mid-stall but grant stays on data
    set_std_payload();
    data_req = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) inst_req = 1'b1;
      #1;
      chk($sformatf("stall%0d mem_req", k), {31'd0, mem_req}, 32'd1);
      chk($sformatf("stall%0d mem_addr", k), mem_addr, DA);
      chk($sformatf("stall%0d mem_wdata", k), mem_wdata, 32'h2222_0000);
      chk($sformatf("stall%0d addr_ok", k), {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      tick();
    end
    mem_addr_ok = 1'b1;
    #1;
    chk("stall accept addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0077;
    #1;
    chk("stall data resp", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
    chk("stall data rdata", data_rdata, 32'h0000_0077);
    tick();
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    #1;
    chk("stall inst follow addr", mem_addr, IA);
    chk("stall inst addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #1;
    chk("stall inst data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
    tick();
    mem_data_ok = 1'b0;

    // asynchronous reset while waiting for data_ok
    data_req = 1'b1;
    tick();
    mem_addr_ok = 1'b1;
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    #3;
    reset = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h55AA_55AA;
    #1;
    chk_quiet("async reset");
    tick();
    mem_data_ok = 1'b0;
    reset = 1'b0;
    #1;
    chk_quiet("post reset idle");
    data_req = 1'b1;
    tick();
    mem_addr_ok = 1'b1;
    #1;
    chk("post reset data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    tick();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h600D_CAFE;
    #1;
    chk("post reset data_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("post reset rdata", data_rdata, 32'h600D_CAFE);
    tick();
    #1;
    chk("stale data_ok in idle", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk_quiet("final idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
